led_scan_controller: RTL and testbench

//   Column-scan sequencer that sits directly upstream of the LED array driver.
//   - Accepts complete NxN Conway frames from the game engine over a valid/ready handshake.
//   - Double-buffers each frame so the displayed frame changes only at a frame boundary.
//   - Steps the driver's column select x through 0..N-1 with a fixed dwell per column.
//   - Inserts a blanking gap (ena low) between columns to suppress ghosting.
//

---
 rtl/led_scan_controller.sv | 145 ++++++++++++++
 tb/tb_led_scan_controller.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/led_scan_controller.sv
// Column-scan sequencer for an NxN LED array: double-buffers incoming frames,
// steps the column select with a fixed dwell, and blanks between columns.
module led_scan_controller #(
    parameter int N            = 5,
    parameter int DWELL_CYCLES = 1000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N*N-1:0]       cells_in,
    input  logic                 cells_valid,
    output logic                 cells_ready,
    output logic                 ena,
    output logic [$clog2(N):0]   x,
    output logic [N*N-1:0]       cells_out,
    output logic                 frame_done
);

    localparam int XW      = $clog2(N) + 1;
    localparam int MAX_CNT = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CW      = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

    localparam logic [CW-1:0] LAST_DWELL = CW'(DWELL_CYCLES - 1);
    localparam logic [CW-1:0] LAST_BLANK = (BLANK_CYCLES > 0) ? CW'(BLANK_CYCLES - 1) : '0;
    localparam logic [XW-1:0] LAST_X     = XW'(N - 1);

    if (N < 1 || N > 8) begin : g_bad_n
        $error("led_scan_controller: N=%0d outside legal range 1..8", N);
    end
    if (DWELL_CYCLES < 1) begin : g_bad_dwell
        $error("led_scan_controller: DWELL_CYCLES=%0d must be >= 1", DWELL_CYCLES);
    end
    if (BLANK_CYCLES < 0) begin : g_bad_blank
        $error("led_scan_controller: BLANK_CYCLES=%0d must be >= 0", BLANK_CYCLES);
    end

    typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XW-1:0]   x_q, x_d;
    logic [N*N-1:0]  pending_q, pending_d;
    logic            pending_full_q, pending_full_d;
    logic [N*N-1:0]  cells_out_q, cells_out_d;
    logic            cells_ready_q, cells_ready_d;
    logic            ena_q, ena_d;
    logic            frame_done_q, frame_done_d;

    logic last_blank, last_drive, last_col, accept;

    assign last_blank = (cnt_q == LAST_BLANK);
    assign last_drive = (cnt_q == LAST_DWELL);
    assign last_col   = (x_q == LAST_X);
    assign accept     = cells_valid && cells_ready_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            x_q            <= '0;
            pending_q      <= '0;
            pending_full_q <= 1'b0;
            cells_out_q    <= '0;
            cells_ready_q  <= 1'b1;
            ena_q          <= 1'b0;
            frame_done_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            x_q            <= x_d;
            pending_q      <= pending_d;
            pending_full_q <= pending_full_d;
            cells_out_q    <= cells_out_d;
            cells_ready_q  <= cells_ready_d;
            ena_q          <= ena_d;
            frame_done_q   <= frame_done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pending_full_q) state_d = (BLANK_CYCLES == 0) ? DRIVE : BLANK;
            BLANK:   if (last_blank)     state_d = DRIVE;
            DRIVE:   if (last_drive)     state_d = (BLANK_CYCLES == 0) ? DRIVE : BLANK;
            default:                     state_d = IDLE;
        endcase
    end

    // ena/ready are computed from next-state values so the registered copies
    // line up with the cycle the state/buffer actually holds.
    always_comb begin
        cnt_d          = cnt_q;
        x_d            = x_q;
        pending_d      = pending_q;
        pending_full_d = pending_full_q;
        cells_out_d    = cells_out_q;
        frame_done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (pending_full_q) begin
                    cells_out_d    = pending_q;
                    pending_full_d = 1'b0;
                    x_d            = '0;
                    cnt_d          = '0;
                end
            end
            BLANK: begin
                cnt_d = last_blank ? '0 : cnt_q + 1'b1;
            end
            DRIVE: begin
                cnt_d = last_drive ? '0 : cnt_q + 1'b1;
                if (last_drive) begin
                    if (last_col) begin
                        x_d          = '0;
                        frame_done_d = 1'b1;
                        if (pending_full_q) begin
                            cells_out_d    = pending_q;
                            pending_full_d = 1'b0;
                        end
                    end else begin
                        x_d = x_q + 1'b1;
                    end
                end
            end
            default: begin
                cnt_d = '0;
            end
        endcase
        // Accept never coincides with a load/swap: ready is low while pending is full.
        if (accept) begin
            pending_d      = cells_in;
            pending_full_d = 1'b1;
        end
        ena_d         = (state_d == DRIVE);
        cells_ready_d = !pending_full_d;
    end

    assign cells_ready = cells_ready_q;
    assign ena         = ena_q;
    assign x           = x_q;
    assign cells_out   = cells_out_q;
    assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_led_scan_controller.sv
// Self-checking bench: two instances (B=1/D=4 and B=0/D=1) driven by shared random
// stimulus, compared each cycle against a timeline-based reference model.
module tb_led_scan_controller;

    localparam int N = 5;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N*N-1:0]   cells_in;
    logic             cells_valid;

    logic             rdy_a, ena_a, fd_a, rdy_b, ena_b, fd_b;
    logic [3:0]       x_a, x_b;
    logic [N*N-1:0]   out_a, out_b;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    led_scan_controller #(.N(N), .DWELL_CYCLES(4), .BLANK_CYCLES(1)) u_a (
        .clk(clk), .rst_n(rst_n), .cells_in(cells_in), .cells_valid(cells_valid),
        .cells_ready(rdy_a), .ena(ena_a), .x(x_a), .cells_out(out_a), .frame_done(fd_a)
    );

    led_scan_controller #(.N(N), .DWELL_CYCLES(1), .BLANK_CYCLES(0)) u_b (
        .clk(clk), .rst_n(rst_n), .cells_in(cells_in), .cells_valid(cells_valid),
        .cells_ready(rdy_b), .ena(ena_b), .x(x_b), .cells_out(out_b), .frame_done(fd_b)
    );

    // Reference model: after load, everything follows from cycles elapsed since load.
    int              m_blank [2] = '{1, 0};
    int              m_per   [2] = '{5, 1};
    bit              m_loaded[2];
    int              m_t     [2];
    bit              m_pfull [2];
    logic [N*N-1:0]  m_pend  [2];
    logic [N*N-1:0]  m_disp  [2];

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                m_loaded[k] = 0; m_t[k] = 0; m_pfull[k] = 0;
                m_pend[k] = '0;  m_disp[k] = '0;
            end else begin
                bit acc;
                acc = cells_valid && !m_pfull[k];
                if (!m_loaded[k]) begin
                    if (m_pfull[k]) begin
                        m_disp[k] = m_pend[k]; m_pfull[k] = 0;
                        m_loaded[k] = 1; m_t[k] = 0;
                    end
                end else begin
                    m_t[k]++;
                    if (m_t[k] % (N * m_per[k]) == 0 && m_pfull[k]) begin
                        m_disp[k] = m_pend[k]; m_pfull[k] = 0;
                    end
                end
                if (acc) begin
                    m_pend[k] = cells_in; m_pfull[k] = 1;
                end
            end
        end
    end

    function automatic bit exp_ena(int k);
        return m_loaded[k] && ((m_t[k] % m_per[k]) >= m_blank[k]);
    endfunction

    function automatic int exp_x(int k);
        return m_loaded[k] ? (m_t[k] / m_per[k]) % N : 0;
    endfunction

    function automatic bit exp_fd(int k);
        return m_loaded[k] && m_t[k] > 0 && (m_t[k] % (N * m_per[k]) == 0);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic check_all();
        check("a.ready", 32'(rdy_a), 32'(!m_pfull[0]));
        check("a.ena",   32'(ena_a), 32'(exp_ena(0)));
        check("a.x",     32'(x_a),   32'(exp_x(0)));
        check("a.out",   32'(out_a), 32'(m_disp[0]));
        check("a.fd",    32'(fd_a),  32'(exp_fd(0)));
        check("b.ready", 32'(rdy_b), 32'(!m_pfull[1]));
        check("b.ena",   32'(ena_b), 32'(exp_ena(1)));
        check("b.x",     32'(x_b),   32'(exp_x(1)));
        check("b.out",   32'(out_b), 32'(m_disp[1]));
        check("b.fd",    32'(fd_b),  32'(exp_fd(1)));
    endtask

    task automatic step();
        @(negedge clk);
        check_all();
    endtask

    initial begin
        int fd_count;
        bit hit;
        rst_n = 1'b0; cells_valid = 1'b0; cells_in = '0;
        repeat (2) step();
        rst_n = 1'b1;
        repeat (10) step();                      // idle: reset values hold

        cells_in = 25'h1555555; cells_valid = 1'b1;
        step();
        cells_valid = 1'b0; cells_in = $urandom;
        fd_count = 0;
        for (int i = 0; i < 80; i++) begin       // free-run on frame A
            step();
            if (fd_a) fd_count++;
        end
        check("a.fd_count_80", 32'(fd_count), 32'd3);

        for (int i = 0; i < 400; i++) begin      // sparse random offers
            cells_valid = ($urandom_range(0, 29) == 0);
            cells_in = $urandom;
            step();
        end

        cells_valid = 1'b1;                      // valid held high, data churning
        for (int i = 0; i < 200; i++) begin
            cells_in = $urandom;
            step();
        end
        cells_valid = 1'b0;

        hit = 0;                                 // reset mid-DRIVE of instance a
        for (int i = 0; i < 50 && !hit; i++) begin
            step();
            hit = exp_ena(0);
        end
        check("a.reached_drive", 32'(hit), 32'd1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        repeat (5) step();

        for (int i = 0; i < 300; i++) begin
            cells_valid = ($urandom_range(0, 9) == 0);
            cells_in = $urandom;
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
